adsb_ppm_encoder: RTL

//   Transmit-side counterpart of decoder_core. Latches one 112-bit Mode-S message and emits a
//   120 us pulse-position-modulated (PPM) sample stream at SAMPLES_PER_US samples/us.
//   The frame is an 8 us preamble followed by 112 data bit-periods of 1 us each.

---
 rtl/adsb_ppm_encoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/adsb_ppm_encoder.sv
// Mode-S PPM frame generator: latches a 112-bit message and plays an 8 us preamble plus 112 PPM bits.
// First sample is one cycle after an accepted start; en=0 stalls output in place (no sample is lost).
module adsb_ppm_encoder #(
  parameter int          SAMPLES_PER_US = 80,
  parameter int          PRE_US         = 8,
  parameter int          DATA_BITS      = 112,
  parameter logic [7:0]  AMP_HIGH       = 8'd255,
  parameter logic [7:0]  AMP_LOW        = 8'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [7:0]           data_out,
  output logic                 valid_out,
  output logic                 busy,
  output logic                 done
);

  localparam int FRAME_US = PRE_US + DATA_BITS;
  localparam int SW       = (SAMPLES_PER_US > 1) ? $clog2(SAMPLES_PER_US) : 1;
  localparam int UW       = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

  localparam logic [SW-1:0] S_LAST     = SW'(SAMPLES_PER_US - 1);
  localparam logic [SW-1:0] S_HALF     = SW'(SAMPLES_PER_US / 2);
  localparam logic [UW-1:0] U_PRE_LAST = UW'(PRE_US - 1);
  localparam logic [UW-1:0] U_LAST     = UW'(FRAME_US - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DONE
  } state_t;

  state_t                 state;
  logic [SW-1:0]          cnt_s;
  logic [UW-1:0]          cnt_us;
  logic [DATA_BITS-1:0]   shreg;

  logic first_half;
  logic pre_pulse;
  logic data_pulse;
  logic pulse_on;
  logic s_wrap;

  // The counters address the sample emitted on the next enabled edge.
  always_comb begin
    first_half = (cnt_s < S_HALF);
    pre_pulse  = ((cnt_us == UW'(0) || cnt_us == UW'(1)) && first_half) ||
                 ((cnt_us == UW'(3) || cnt_us == UW'(4)) && !first_half);
    data_pulse = shreg[DATA_BITS-1] ? first_half : !first_half;
    pulse_on   = (state == PRE) ? pre_pulse : data_pulse;
    s_wrap     = (cnt_s == S_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt_s     <= '0;
      cnt_us    <= '0;
      shreg     <= '0;
      data_out  <= AMP_LOW;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          data_out  <= AMP_LOW;
          valid_out <= 1'b0;
          busy      <= 1'b0;
          if (start && en) begin
            // Sample 0 (first half of the leading preamble pulse) goes out right away.
            state     <= PRE;
            shreg     <= data_in;
            cnt_us    <= '0;
            cnt_s     <= SW'(1);
            busy      <= 1'b1;
            valid_out <= 1'b1;
            data_out  <= AMP_HIGH;
          end
        end

        PRE, DATA: begin
          if (!en) begin
            valid_out <= 1'b0;
            data_out  <= AMP_LOW;
          end else begin
            valid_out <= 1'b1;
            data_out  <= pulse_on ? AMP_HIGH : AMP_LOW;
            if (s_wrap) begin
              cnt_s  <= '0;
              cnt_us <= cnt_us + UW'(1);
              if (state == DATA) begin
                shreg <= {shreg[DATA_BITS-2:0], 1'b0};
              end
              if (state == PRE && cnt_us == U_PRE_LAST) begin
                state <= DATA;
              end
              if (state == DATA && cnt_us == U_LAST) begin
                state  <= DONE;
                cnt_us <= '0;
              end
            end else begin
              cnt_s <= cnt_s + SW'(1);
            end
          end
        end

        DONE: begin
          state     <= IDLE;
          valid_out <= 1'b0;
          data_out  <= AMP_LOW;
          done      <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
